windowed_register_file: RTL and testbench
=========================================

WINDOWED_REGISTER_FILE -- requirements
Module: windowed_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NWIN, default 8, number of register windows (legal range 2..32).
REQ-003 SHALL have parameter CWPW, default $clog2(NWIN), window pointer width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous reset, active-high.
REQ-006 RA, RB  input  5  logical read addresses, ports A and B.
REQ-007 RD  input  5  logical write address.
REQ-008 Din  input  WIDTH  write data.
REQ-009 WE  input  1  register write enable.
REQ-010 Save, Restore  input  1 each  window decrement and increment requests.
REQ-011 CwpWe  input  1  direct CWP load; CwpIn  input  CWPW  load value.
REQ-012 WimWe  input  1  WIM load; WimIn  input  NWIN  load value.
REQ-013 Aout, Bout  output  WIDTH  read data, ports A and B.
REQ-014 Cwp  output  CWPW  current window pointer; Wim  output  NWIN  window invalid mask.
REQ-015 Ovf, Unf, IllOp  output  1 each  registered one-cycle trap pulses.

Function
REQ-016 Logical map SHALL be: r0-r7 globals; r8-r15 outs; r16-r23 locals; r24-r31 ins.
REQ-017 Ins of window w SHALL be the same physical registers as outs of window (w+1) mod NWIN.
REQ-018 Physical storage SHALL be 8 globals plus NWIN*16 windowed registers (locals and outs per window).
REQ-019 Aout/Bout SHALL be combinational from RA/RB and the current Cwp; r0 SHALL always read 0.
REQ-020 Read during a same-cycle write to the same register SHALL return the old value (no bypass).
REQ-021 Writes SHALL take effect at the clock edge; the address SHALL map using Cwp before any same-cycle update; writes to r0 SHALL be discarded.
REQ-022 Save SHALL set Cwp to (Cwp-1) mod NWIN, unless Wim[(Cwp-1) mod NWIN]=1; then Cwp holds and Ovf pulses high for the next cycle.
REQ-023 Restore SHALL set Cwp to (Cwp+1) mod NWIN, unless Wim[(Cwp+1) mod NWIN]=1; then Cwp holds and Unf pulses high for the next cycle.
REQ-024 Save and Restore asserted together SHALL leave Cwp unchanged and pulse IllOp, with no Ovf/Unf.
REQ-025 CwpWe SHALL override Save/Restore, load CwpIn mod NWIN, and suppress Ovf, Unf and IllOp that cycle.
REQ-026 WimWe SHALL load WimIn at the edge; trap checks in the same cycle SHALL use the old Wim.
REQ-027 A trapped Save/Restore SHALL NOT block a same-cycle register write.
REQ-028 Wrap-around at 0 and NWIN-1 SHALL be modular with no trap unless set by Wim.

Reset
REQ-029 Rst SHALL clear Cwp, Wim, Ovf, Unf, IllOp and all physical registers to 0; Aout/Bout SHALL read 0 in the cycle after reset.
REQ-030 Rst SHALL take priority over all other inputs, including mid-operation writes and window moves.

Structure
REQ-031 A shared package SHALL hold the constants NGLOBAL=8 and WINREGS=16, plus the region enumeration (GLOBAL, OUT, LOCAL, IN).
REQ-032 One sub-module, window_addr_map, SHALL convert a logical address and Cwp to a physical index and SHALL be instantiated three times (A, B, RD).
REQ-033 Cwp, Wim and trap logic SHALL reside in the top level; the target implementation size is 120-400 lines.

Verification (WIDTH=32, NWIN=8)
REQ-034 Reset, write r0=0xDEADBEEF, read r0 and r5 -> both read 0x00000000.
REQ-035 Cwp=3, write r8=0x11111111, Save -> Cwp=2, r24 reads 0x11111111.
REQ-036 Cwp=0, Save -> Cwp=7, no Ovf; Restore -> Cwp=0, no Unf.
REQ-037 Wim=0x04, Cwp=3, Save -> Ovf=1 for one cycle, Cwp stays 3; Save+Restore together -> IllOp=1, Cwp unchanged.
REQ-038 Cwp=3, write r16=0xA5A5A5A5 with Save in same cycle -> Cwp=2, r16 reads 0; Restore -> r16 reads 0xA5A5A5A5.
REQ-039 Rst asserted with WE=1 and Save=1 -> Cwp=0, target register 0, no trap pulse.

Source files
------------

// File: rtl/windowed_register_file_pkg.sv
// Shared constants and the logical register region decode for the windowed register file.
package windowed_register_file_pkg;

  localparam int NGLOBAL = 8;
  localparam int WINREGS = 16;

  typedef enum logic [1:0] {
    GLOBAL = 2'd0,
    OUT    = 2'd1,
    LOCAL  = 2'd2,
    IN     = 2'd3
  } region_e;

  function automatic region_e regionOf(input logic [4:0] addr);
    return region_e'(addr[4:3]);
  endfunction

endpackage

// File: rtl/window_addr_map.sv
// Maps a logical register address plus the current window pointer onto a physical index.
// Physical layout: globals at 0..7, then one 16-entry block per window (outs, then locals).
module window_addr_map
  import windowed_register_file_pkg::*;
#(
  parameter int NWIN  = 8,
  parameter int CWPW  = $clog2(NWIN),
  parameter int PIDXW = $clog2(NGLOBAL + NWIN * WINREGS)
) (
  input  logic [4:0]       logAddr_i,
  input  logic [CWPW-1:0]  cwp_i,
  output logic [PIDXW-1:0] physIdx_o
);

  region_e          region;
  logic [CWPW-1:0]  nextWin;
  logic [CWPW-1:0]  window;
  logic [PIDXW-1:0] slot;

  // Ins have no storage of their own: they alias the outs of the next window up.
  always_comb begin
    region  = regionOf(logAddr_i);
    nextWin = (cwp_i == CWPW'(NWIN - 1)) ? '0 : cwp_i + CWPW'(1);
    window  = (region == IN) ? nextWin : cwp_i;
    slot    = (region == LOCAL) ? PIDXW'(8) : '0;
    if (region == GLOBAL) begin
      physIdx_o = PIDXW'(logAddr_i[2:0]);
    end else begin
      physIdx_o = PIDXW'(NGLOBAL) + PIDXW'(window) * PIDXW'(WINREGS)
                + slot + PIDXW'(logAddr_i[2:0]);
    end
  end

endmodule

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: two combinational read ports, one write port,
// and a current window pointer that moves on Save/Restore, guarded by the window invalid mask.
module windowed_register_file
  import windowed_register_file_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NWIN  = 8,
  parameter int CWPW  = $clog2(NWIN)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RD,
  input  logic [WIDTH-1:0] Din,
  input  logic             WE,
  input  logic             Save,
  input  logic             Restore,
  input  logic             CwpWe,
  input  logic [CWPW-1:0]  CwpIn,
  input  logic             WimWe,
  input  logic [NWIN-1:0]  WimIn,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic [CWPW-1:0]  Cwp,
  output logic [NWIN-1:0]  Wim,
  output logic             Ovf,
  output logic             Unf,
  output logic             IllOp
);

  localparam int            NPHYS  = NGLOBAL + NWIN * WINREGS;
  localparam int            PIDXW  = $clog2(NPHYS);
  localparam logic [CWPW:0] NWIN_W = (CWPW + 1)'(NWIN);

  logic [WIDTH-1:0] regs_q [NPHYS];
  logic [PIDXW-1:0] physA, physB, physD;

  logic [CWPW-1:0]  cwp_q, cwp_d;
  logic [NWIN-1:0]  wim_q, wim_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             illOp_q, illOp_d;
  logic [CWPW-1:0]  cwpMinus, cwpPlus, cwpLoad;

  window_addr_map #(.NWIN(NWIN), .CWPW(CWPW), .PIDXW(PIDXW)) mapA (
    .logAddr_i(RA), .cwp_i(cwp_q), .physIdx_o(physA)
  );
  window_addr_map #(.NWIN(NWIN), .CWPW(CWPW), .PIDXW(PIDXW)) mapB (
    .logAddr_i(RB), .cwp_i(cwp_q), .physIdx_o(physB)
  );
  window_addr_map #(.NWIN(NWIN), .CWPW(CWPW), .PIDXW(PIDXW)) mapD (
    .logAddr_i(RD), .cwp_i(cwp_q), .physIdx_o(physD)
  );

  assign Aout  = (RA == 5'd0) ? '0 : regs_q[physA];
  assign Bout  = (RB == 5'd0) ? '0 : regs_q[physB];
  assign Cwp   = cwp_q;
  assign Wim   = wim_q;
  assign Ovf   = ovf_q;
  assign Unf   = unf_q;
  assign IllOp = illOp_q;

  // A direct load wins outright; otherwise a move is refused (and trapped) when the
  // destination window is marked invalid in the mask as it stood before this edge.
  always_comb begin
    cwpMinus = (cwp_q == '0) ? CWPW'(NWIN - 1) : cwp_q - CWPW'(1);
    cwpPlus  = (cwp_q == CWPW'(NWIN - 1)) ? '0 : cwp_q + CWPW'(1);
    cwpLoad  = ({1'b0, CwpIn} >= NWIN_W) ? CwpIn - NWIN_W[CWPW-1:0] : CwpIn;
    cwp_d    = cwp_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    illOp_d  = 1'b0;
    wim_d    = WimWe ? WimIn : wim_q;
    if (CwpWe) begin
      cwp_d = cwpLoad;
    end else if (Save && Restore) begin
      illOp_d = 1'b1;
    end else if (Save) begin
      if (wim_q[cwpMinus]) ovf_d = 1'b1;
      else                 cwp_d = cwpMinus;
    end else if (Restore) begin
      if (wim_q[cwpPlus]) unf_d = 1'b1;
      else                cwp_d = cwpPlus;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cwp_q   <= '0;
      wim_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      illOp_q <= 1'b0;
    end else begin
      cwp_q   <= cwp_d;
      wim_q   <= wim_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      illOp_q <= illOp_d;
    end
  end

  // The write address was mapped with the pre-edge window, so a same-cycle move
  // never redirects the write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
    end else if (WE && (RD != 5'd0)) begin
      regs_q[physD] <= Din;
    end
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench for windowed_register_file: directed vector table, a window-chain
// sequence, then randomized traffic against a register-window reference model.
module tb_windowed_register_file;

  localparam int WIDTH = 32;
  localparam int NWIN  = 8;
  localparam int CWPW  = 3;

  logic             Clk = 1'b0;
  logic             Rst, WE, Save, Restore, CwpWe, WimWe;
  logic [4:0]       RA, RB, RD;
  logic [WIDTH-1:0] Din;
  logic [CWPW-1:0]  CwpIn;
  logic [NWIN-1:0]  WimIn;
  logic [WIDTH-1:0] Aout, Bout;
  logic [CWPW-1:0]  Cwp;
  logic [NWIN-1:0]  Wim;
  logic             Ovf, Unf, IllOp;

  int total = 0;
  int bad   = 0;

  windowed_register_file #(.WIDTH(WIDTH), .NWIN(NWIN), .CWPW(CWPW)) dut (
    .Clk(Clk), .Rst(Rst), .RA(RA), .RB(RB), .RD(RD), .Din(Din), .WE(WE),
    .Save(Save), .Restore(Restore), .CwpWe(CwpWe), .CwpIn(CwpIn),
    .WimWe(WimWe), .WimIn(WimIn), .Aout(Aout), .Bout(Bout), .Cwp(Cwp),
    .Wim(Wim), .Ovf(Ovf), .Unf(Unf), .IllOp(IllOp)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, we, save, restore, cwpWe, wimWe;
    logic [4:0]  ra, rb, rd;
    logic [31:0] din;
    logic [2:0]  cwpIn;
    logic [7:0]  wimIn;
  } stim_t;

  // expA/expB are the reads seen during the cycle; the rest are the state after its edge.
  typedef struct {
    stim_t       s;
    logic [31:0] expA, expB;
    logic [2:0]  expCwp;
    logic [7:0]  expWim;
    logic        expOvf, expUnf, expIll;
  } vec_t;

  // Reference model: architectural view of globals, per-window outs/locals, window pointer.
  logic [31:0] mGlob [8];
  logic [31:0] mOut  [NWIN][8];
  logic [31:0] mLoc  [NWIN][8];
  int          mCwp;
  logic [7:0]  mWim;
  logic        mOvf, mUnf, mIll;

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    int off = int'(a[2:0]);
    if (a == 5'd0) return 32'd0;
    case (int'(a) / 8)
      0:       return mGlob[off];
      1:       return mOut[mCwp][off];
      2:       return mLoc[mCwp][off];
      default: return mOut[(mCwp + 1) % NWIN][off];
    endcase
  endfunction

  task automatic modelStep(input stim_t s);
    int off = int'(s.rd[2:0]);
    int n;
    if (s.rst) begin
      for (int i = 0; i < 8; i++) begin
        mGlob[i] = '0;
        for (int w = 0; w < NWIN; w++) begin
          mOut[w][i] = '0;
          mLoc[w][i] = '0;
        end
      end
      mCwp = 0; mWim = '0; mOvf = 0; mUnf = 0; mIll = 0;
      return;
    end
    if (s.we && s.rd != 5'd0) begin
      case (int'(s.rd) / 8)
        0:       mGlob[off] = s.din;
        1:       mOut[mCwp][off] = s.din;
        2:       mLoc[mCwp][off] = s.din;
        default: mOut[(mCwp + 1) % NWIN][off] = s.din;
      endcase
    end
    mOvf = 0; mUnf = 0; mIll = 0;
    if (s.cwpWe) begin
      mCwp = int'(s.cwpIn) % NWIN;
    end else if (s.save && s.restore) begin
      mIll = 1;
    end else if (s.save) begin
      n = (mCwp + NWIN - 1) % NWIN;
      if (mWim[n]) mOvf = 1; else mCwp = n;
    end else if (s.restore) begin
      n = (mCwp + 1) % NWIN;
      if (mWim[n]) mUnf = 1; else mCwp = n;
    end
    if (s.wimWe) mWim = s.wimIn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%h want=0x%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    Rst = s.rst; WE = s.we; Save = s.save; Restore = s.restore;
    CwpWe = s.cwpWe; CwpIn = s.cwpIn; WimWe = s.wimWe; WimIn = s.wimIn;
    RA = s.ra; RB = s.rb; RD = s.rd; Din = s.din;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.we = 0; s.save = 0; s.restore = 0; s.cwpWe = 0; s.wimWe = 0;
    s.ra = 0; s.rb = 0; s.rd = 0; s.din = 0; s.cwpIn = 0; s.wimIn = 0;
    return s;
  endfunction

  function automatic vec_t row(input logic rst, we, save, restore, cwpWe,
                               input logic [2:0] cwpIn, input logic wimWe,
                               input logic [7:0] wimIn, input logic [4:0] rd,
                               input logic [31:0] din, input logic [4:0] ra, rb,
                               input logic [31:0] expA, expB, input logic [2:0] expCwp,
                               input logic [7:0] expWim, input logic expOvf, expUnf, expIll);
    vec_t v;
    v.s.rst = rst; v.s.we = we; v.s.save = save; v.s.restore = restore;
    v.s.cwpWe = cwpWe; v.s.cwpIn = cwpIn; v.s.wimWe = wimWe; v.s.wimIn = wimIn;
    v.s.rd = rd; v.s.din = din; v.s.ra = ra; v.s.rb = rb;
    v.expA = expA; v.expB = expB; v.expCwp = expCwp; v.expWim = expWim;
    v.expOvf = expOvf; v.expUnf = expUnf; v.expIll = expIll;
    return v;
  endfunction

  task automatic runRow(input int idx, input vec_t v);
    applyStimulus(v.s);
    #2;
    checkOutput($sformatf("row%0d.Aout", idx), Aout, v.expA);
    checkOutput($sformatf("row%0d.Bout", idx), Bout, v.expB);
    @(posedge Clk); #1;
    modelStep(v.s);
    checkOutput($sformatf("row%0d.Cwp", idx), 32'(Cwp), 32'(v.expCwp));
    checkOutput($sformatf("row%0d.Wim", idx), 32'(Wim), 32'(v.expWim));
    checkOutput($sformatf("row%0d.Ovf", idx), 32'(Ovf), 32'(v.expOvf));
    checkOutput($sformatf("row%0d.Unf", idx), 32'(Unf), 32'(v.expUnf));
    checkOutput($sformatf("row%0d.IllOp", idx), 32'(IllOp), 32'(v.expIll));
  endtask

  task automatic runModelCycle(input string tag, input stim_t s);
    applyStimulus(s);
    #2;
    checkOutput({tag, ".Aout"}, Aout, modelRead(s.ra));
    checkOutput({tag, ".Bout"}, Bout, modelRead(s.rb));
    @(posedge Clk); #1;
    modelStep(s);
    checkOutput({tag, ".Cwp"}, 32'(Cwp), 32'(mCwp));
    checkOutput({tag, ".Wim"}, 32'(Wim), 32'(mWim));
    checkOutput({tag, ".Ovf"}, 32'(Ovf), 32'(mOvf));
    checkOutput({tag, ".Unf"}, 32'(Unf), 32'(mUnf));
    checkOutput({tag, ".IllOp"}, 32'(IllOp), 32'(mIll));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  tbl[$];
    stim_t s;

    //              rst we sv rs cWe cIn wWe wIn    rd  din           ra  rb  expA          expB          cwp wim    o u i
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,  32'hDEADBEEF, 0,  5,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        0,  5,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 3, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, 8'h00, 8,  32'h11111111, 8,  8,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,  32'h0,        8,  24, 32'h11111111, 32'h0,        2, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        24, 8,  32'h11111111, 32'h0,        2, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        7, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 3, 1, 8'h04, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h04, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 1, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h04, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 1, 8'h10, 0,  32'h0,        0,  0,  32'h0,        32'h0,        4, 8'h10, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 3, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h10, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h10, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 1, 1, 0, 0, 0, 0, 8'h00, 16, 32'hA5A5A5A5, 16, 0,  32'h0,        32'h0,        2, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 8'h00, 0,  32'h0,        16, 0,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        16, 0,  32'hA5A5A5A5, 32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 8'h04, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 1, 1, 0, 0, 0, 0, 8'h00, 17, 32'h12345678, 0,  0,  32'h0,        32'h0,        3, 8'h04, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        17, 0,  32'h12345678, 32'h0,        3, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 0, 1, 0, 1, 5, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        5, 8'h04, 0, 0, 0));
    tbl.push_back(row(1, 1, 1, 0, 0, 0, 0, 8'h00, 9,  32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,        0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 5, 0, 8'h00, 0,  32'h0,        9,  17, 32'h0,        32'h0,        5, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        9,  17, 32'h0,        32'h0,        5, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 3, 0, 8'h00, 0,  32'h0,        0,  0,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,  32'h0,        16, 8,  32'h0,        32'h0,        3, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) runRow(i, tbl[i]);

    // Window chain: r8 written in every window must reappear as r24 of the window below it.
    for (int w = 0; w < NWIN; w++) begin
      s = idle(); s.cwpWe = 1; s.cwpIn = 3'(w);
      runModelCycle("chainSel", s);
      s = idle(); s.we = 1; s.rd = 5'd8; s.din = 32'hC0DE0000 + 32'(w);
      runModelCycle("chainWr", s);
    end
    for (int w = 0; w < NWIN; w++) begin
      s = idle(); s.cwpWe = 1; s.cwpIn = 3'(w);
      runModelCycle("chainSel", s);
      s = idle(); s.ra = 5'd24; s.rb = 5'd8;
      applyStimulus(s);
      #2;
      checkOutput($sformatf("chainIn%0d", w), Aout, 32'hC0DE0000 + 32'((w + 1) % NWIN));
      checkOutput($sformatf("chainOut%0d", w), Bout, 32'hC0DE0000 + 32'(w));
      @(posedge Clk); #1;
      modelStep(s);
    end

    for (int n = 0; n < 800; n++) begin
      s.rst     = ($urandom_range(0, 63) == 0);
      s.we      = $urandom_range(0, 1) == 1;
      s.save    = ($urandom_range(0, 3) == 0);
      s.restore = ($urandom_range(0, 3) == 0);
      s.cwpWe   = ($urandom_range(0, 15) == 0);
      s.cwpIn   = 3'($urandom);
      s.wimWe   = ($urandom_range(0, 15) == 0);
      s.wimIn   = 8'($urandom & $urandom);
      s.ra      = 5'($urandom);
      s.rb      = 5'($urandom);
      s.rd      = 5'($urandom);
      s.din     = $urandom;
      runModelCycle($sformatf("rand%0d", n), s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
